pc_fetch_redirect: RTL and testbench
====================================

# pc_fetch_redirect

Owns the fetch-stage program counter and consumes the redirect request that the branch/jump unit produces in EX. Each cycle it chooses the next fetch address from sequential (PC+4), hold (hazard stall or instruction-memory busywait), or redirect (branch taken or jump target). It also drives the flushes that squash wrong-path instructions in IF/ID and ID/EX. When a redirect arrives while instruction memory is busy, the block keeps the target pending and applies it once the fetch completes.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- CNT_W, 16, width of the saturating redirect counter
- CLK  in  1  pipeline clock; all state changes on rising edge
- RESETn  in  1  asynchronous, active-low reset
- branch_jump_mux_signal  in  1  redirect request from the branch/jump unit (taken branch or jump)
- Branch_jump_PC_OUT  in  32  redirect target, valid when branch_jump_mux_signal=1
- stall  in  1  load-use stall from the hazard unit; hold PC
- imem_busywait  in  1  instruction memory has not completed the current fetch
- imem_read  out  1  fetch request to instruction memory
- PC  out  32  current fetch address
- PC_plus4  out  32  PC+4, forwarded down the pipe for JAL/JALR link
- flush_if_id  out  1  squash the IF/ID register this cycle
- flush_id_ex  out  1  squash the ID/EX register this cycle
- target_misaligned  out  1  one-cycle pulse: the accepted target had [1:0]≠0
- redirect_cnt  out  CNT_W  number of redirects applied, saturating

## Operation
- FSM states: RUN and PEND. Reset state is RUN.
- **RUN, redirect=1, busywait=0:**
  - PC <= {target[31:2],2'b00}.
  - flush_if_id=1 and flush_id_ex=1 this cycle.
  - redirect_cnt increments.
  - Stay in RUN.
- **RUN, redirect=1, busywait=1:**
  - pend_pc <= {target[31:2],2'b00}.
  - flush_if_id=1 and flush_id_ex=1 this cycle.
  - Go to PEND. PC holds.
- **RUN, redirect=0:**
  - If stall or busywait, PC holds.
  - Otherwise PC <= PC+4.
- **PEND, busywait=1:**
  - PC holds.
  - A new redirect overwrites pend_pc (latest wins) and asserts both flushes again.
- **PEND, busywait=0:**
  - PC <= pend_pc, or the new target if a redirect is present this cycle.
  - flush_if_id=1, because the returning word is wrong-path. flush_id_ex=0 unless a redirect is present.
  - redirect_cnt increments.
  - Go to RUN.
- Priority: redirect beats stall. Stall does not block applying a pending target.
- Misaligned target: target[1:0] is forced to 00 and the redirect still applies. target_misaligned is registered and pulses for 1 cycle after the acceptance cycle.
- imem_read=1 whenever RESETn=1. It is 0 during reset.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. redirect_cnt saturates at all-ones and never wraps.

## Timing
- Reset (asynchronous, RESETn=0) values:
  - PC=RESET_PC, pend_pc=0, state=RUN, redirect_cnt=0.
  - target_misaligned=0, imem_read=0, flushes=0.
  - PC_plus4=RESET_PC+4.
- Redirect-to-PC latency is 1 edge in RUN. In PEND, the target applies at the first edge where busywait=0.
- flush_if_id and flush_id_ex are combinational from the inputs and state. They are valid in the same cycle as the redirect, so they act on the same edge that loads the target.
- PC_plus4 is combinational from PC.
- Reset asserted during PEND discards pend_pc. The first fetch after reset release is at RESET_PC.

## Structure
- Shared package riscv_pc_pkg contains:
  - state enum {RUN, PEND}
  - INSN_BYTES=4
  - default RESET_PC
- One sub-module, sat_counter (parameter W; inputs inc, CLK, RESETn; output count). The same package is reused for the performance counters.
- Next-PC mux, FSM, pend_pc register and misaligned flop live in the top module.

## Test plan
- **Reset and sequential fetch:** hold RESETn=0 for 3 cycles, then release with no other inputs active. Expect PC = 0, 4, 8, 12 on successive edges and imem_read=1 after release.
- **Redirect in RUN:** at PC=0x10, pulse redirect with target=0x200. Expect both flushes in that cycle, PC=0x200 next cycle, redirect_cnt=1.
- **Redirect under busywait:** at PC=0x20 with busywait=1 for 3 cycles, redirect to 0x80 in cycle 1. Expect:
  - PC holds at 0x20 for those cycles.
  - In the cycle busywait drops: flush_if_id=1 and flush_id_ex=0.
  - Next cycle: PC=0x80.
- **Redirect vs stall:** assert stall and redirect together with target 0x44. Expect PC=0x44. With stall alone, PC holds.
- **Misaligned target:** redirect to 0x103. Expect PC=0x100 and a one-cycle target_misaligned pulse one cycle later.
- **Wrap, saturation and mid-PEND reset:**
  - With RESET_PC=32'hFFFF_FFFC, expect PC 0xFFFF_FFFC then 0.
  - With CNT_W=2, apply 5 redirects. Expect redirect_cnt to stick at 3.
  - Assert RESETn=0 while in PEND, then release. Expect PC=RESET_PC.

Source files
------------

// File: rtl/riscv_pc_pkg.sv
// rtl/riscv_pc_pkg.sv - shared fetch-stage types and constants
package riscv_pc_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    PEND = 1'b1
  } pc_state_t;

  localparam int unsigned INSN_BYTES       = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating event counter, sticks at all-ones
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RESETn,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pc_fetch_redirect.sv
// rtl/pc_fetch_redirect.sv - fetch PC owner with branch/jump redirect and wrong-path flushes
module pc_fetch_redirect
  import riscv_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          CNT_W    = 16
) (
  input  logic             CLK,
  input  logic             RESETn,
  input  logic             branch_jump_mux_signal,
  input  logic [31:0]      Branch_jump_PC_OUT,
  input  logic             stall,
  input  logic             imem_busywait,
  output logic             imem_read,
  output logic [31:0]      PC,
  output logic [31:0]      PC_plus4,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             target_misaligned,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [31:0] INSN_STEP = 32'(INSN_BYTES);

  pc_state_t   state;
  logic [31:0] pend_pc;
  logic [31:0] target_aligned;
  logic        redirect;
  logic        apply_redirect;

  assign redirect       = branch_jump_mux_signal;
  assign target_aligned = {Branch_jump_PC_OUT[31:2], 2'b00};
  assign PC_plus4       = PC + INSN_STEP;
  assign imem_read      = RESETn;

  // The word returning when a pending target is released is wrong-path, so IF/ID is squashed then too.
  assign flush_id_ex    = RESETn & redirect;
  assign flush_if_id    = RESETn & (redirect | ((state == PEND) & ~imem_busywait));
  assign apply_redirect = ~imem_busywait & (redirect | (state == PEND));

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state             <= RUN;
      PC                <= RESET_PC;
      pend_pc           <= '0;
      target_misaligned <= 1'b0;
    end else begin
      target_misaligned <= redirect & (Branch_jump_PC_OUT[1:0] != 2'b00);
      case (state)
        RUN: begin
          if (redirect) begin
            if (imem_busywait) begin
              pend_pc <= target_aligned;
              state   <= PEND;
            end else begin
              PC <= target_aligned;
            end
          end else if (!stall && !imem_busywait) begin
            PC <= PC_plus4;
          end
        end
        PEND: begin
          // Stall is ignored here: the held target must land as soon as the fetch completes.
          if (imem_busywait) begin
            if (redirect) pend_pc <= target_aligned;
          end else begin
            PC    <= redirect ? target_aligned : pend_pc;
            state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_redirect_cnt (
    .CLK    (CLK),
    .RESETn (RESETn),
    .inc    (apply_redirect),
    .count  (redirect_cnt)
  );

endmodule

// File: tb/tb_pc_fetch_redirect.sv
// tb/tb_pc_fetch_redirect.sv - bench for pc_fetch_redirect, two parameterisations on shared stimulus
module tb_pc_fetch_redirect;

  logic        CLK;
  logic        rstn;
  logic        redir;
  logic [31:0] tgt;
  logic        stall;
  logic        busy;

  logic        imem_w [2];
  logic [31:0] pc_w   [2];
  logic [31:0] p4_w   [2];
  logic        fi_w   [2];
  logic        fe_w   [2];
  logic        mis_w  [2];
  logic [15:0] cnt0;
  logic [1:0]  cnt1;
  logic [15:0] cnt_w  [2];

  assign cnt_w[0] = cnt0;
  assign cnt_w[1] = {14'b0, cnt1};

  int checks = 0;
  int errors = 0;

  pc_fetch_redirect #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut0 (
    .CLK(CLK), .RESETn(rstn), .branch_jump_mux_signal(redir), .Branch_jump_PC_OUT(tgt),
    .stall(stall), .imem_busywait(busy), .imem_read(imem_w[0]), .PC(pc_w[0]),
    .PC_plus4(p4_w[0]), .flush_if_id(fi_w[0]), .flush_id_ex(fe_w[0]),
    .target_misaligned(mis_w[0]), .redirect_cnt(cnt0)
  );

  pc_fetch_redirect #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) dut1 (
    .CLK(CLK), .RESETn(rstn), .branch_jump_mux_signal(redir), .Branch_jump_PC_OUT(tgt),
    .stall(stall), .imem_busywait(busy), .imem_read(imem_w[1]), .PC(pc_w[1]),
    .PC_plus4(p4_w[1]), .flush_if_id(fi_w[1]), .flush_id_ex(fe_w[1]),
    .target_misaligned(mis_w[1]), .redirect_cnt(cnt1)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: what the fetch unit must hold after each edge, from the redirect rules.
  logic [31:0] rst_pc  [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
  int          cnt_max [2] = '{65535, 3};
  logic [31:0] m_pc    [2];
  logic [31:0] m_tgt   [2];
  bit          m_held  [2];
  int          m_cnt   [2];
  bit          m_mis   [2];

  always @(negedge CLK) begin
    for (int k = 0; k < 2; k++) begin
      if (!rstn) begin
        m_pc[k]   = rst_pc[k];
        m_tgt[k]  = 32'h0;
        m_held[k] = 1'b0;
        m_cnt[k]  = 0;
        m_mis[k]  = 1'b0;
      end
      chk($sformatf("d%0d.pc", k), pc_w[k], m_pc[k]);
      chk($sformatf("d%0d.pc_plus4", k), p4_w[k], m_pc[k] + 32'd4);
      chk($sformatf("d%0d.imem_read", k), {31'b0, imem_w[k]}, {31'b0, rstn});
      chk($sformatf("d%0d.flush_id_ex", k), {31'b0, fe_w[k]}, {31'b0, rstn && redir});
      chk($sformatf("d%0d.flush_if_id", k), {31'b0, fi_w[k]},
          {31'b0, rstn && (redir || (m_held[k] && !busy))});
      chk($sformatf("d%0d.misaligned", k), {31'b0, mis_w[k]}, {31'b0, m_mis[k]});
      chk($sformatf("d%0d.redirect_cnt", k), {16'b0, cnt_w[k]}, 32'(m_cnt[k]));
      if (rstn) begin
        logic [31:0] want;
        bit          landed;
        want   = tgt & 32'hFFFF_FFFC;
        landed = 1'b0;
        if (redir && busy) begin
          m_tgt[k]  = want;
          m_held[k] = 1'b1;
        end else if (!busy && (redir || m_held[k])) begin
          m_pc[k]   = redir ? want : m_tgt[k];
          m_held[k] = 1'b0;
          landed    = 1'b1;
        end else if (!busy && !stall) begin
          m_pc[k] = m_pc[k] + 32'd4;
        end
        if (landed && m_cnt[k] < cnt_max[k]) m_cnt[k]++;
        m_mis[k] = redir && (tgt % 4 != 0);
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    rstn = 1'b0; redir = 1'b1; tgt = 32'h40; stall = 1'b0; busy = 1'b0;
    repeat (3) step();
    chk("rst.pc", pc_w[0], 32'h0);
    chk("rst.imem_read", {31'b0, imem_w[0]}, 32'h0);
    chk("rst.flush_if_id", {31'b0, fi_w[0]}, 32'h0);
    chk("rst.wrap_pc_plus4", p4_w[1], 32'h0);

    rstn = 1'b1; redir = 1'b0; tgt = 32'h0;
    #1;
    chk("rel.imem_read", {31'b0, imem_w[0]}, 32'h1);
    chk("rel.pc", pc_w[0], 32'h0);
    chk("rel.d1_pc", pc_w[1], 32'hFFFF_FFFC);
    step(); chk("seq.pc4", pc_w[0], 32'h4); chk("seq.wrap", pc_w[1], 32'h0);
    step(); chk("seq.pc8", pc_w[0], 32'h8);
    step(); chk("seq.pc12", pc_w[0], 32'hC);
    step(); chk("seq.pc16", pc_w[0], 32'h10);

    redir = 1'b1; tgt = 32'h200;
    #1;
    chk("run.flush_if_id", {31'b0, fi_w[0]}, 32'h1);
    chk("run.flush_id_ex", {31'b0, fe_w[0]}, 32'h1);
    step(); chk("run.pc", pc_w[0], 32'h200); chk("run.cnt", {16'b0, cnt0}, 32'd1);

    tgt = 32'h20;
    step(); chk("to20.pc", pc_w[0], 32'h20);
    busy = 1'b1; tgt = 32'h80;
    step(); chk("busy1.pc", pc_w[0], 32'h20);
    redir = 1'b0;
    step(); chk("busy2.pc", pc_w[0], 32'h20);
    step(); chk("busy3.pc", pc_w[0], 32'h20);
    busy = 1'b0;
    #1;
    chk("pend.flush_if_id", {31'b0, fi_w[0]}, 32'h1);
    chk("pend.flush_id_ex", {31'b0, fe_w[0]}, 32'h0);
    step(); chk("pend.pc", pc_w[0], 32'h80); chk("pend.cnt", {16'b0, cnt0}, 32'd3);

    stall = 1'b1; redir = 1'b1; tgt = 32'h44;
    step(); chk("stall_redir.pc", pc_w[0], 32'h44);
    redir = 1'b0;
    step(); chk("stall1.pc", pc_w[0], 32'h44);
    step(); chk("stall2.pc", pc_w[0], 32'h44);

    stall = 1'b0; redir = 1'b1; tgt = 32'h103;
    step(); chk("mis.pc", pc_w[0], 32'h100); chk("mis.pulse", {31'b0, mis_w[0]}, 32'h1);
    redir = 1'b0;
    step(); chk("mis.pc_next", pc_w[0], 32'h104); chk("mis.pulse_end", {31'b0, mis_w[0]}, 32'h0);
    chk("sat.cnt", {30'b0, cnt1}, 32'd3);
    chk("sat.cnt0", {16'b0, cnt0}, 32'd5);

    busy = 1'b1; redir = 1'b1; tgt = 32'h300;
    step();
    tgt = 32'h400;
    #1;
    chk("pend_ovw.flush_id_ex", {31'b0, fe_w[0]}, 32'h1);
    step();
    redir = 1'b0; busy = 1'b0;
    step(); chk("pend_ovw.pc", pc_w[0], 32'h400); chk("pend_ovw.cnt", {16'b0, cnt0}, 32'd6);

    busy = 1'b1; redir = 1'b1; tgt = 32'h500;
    step();
    busy = 1'b0; stall = 1'b1; tgt = 32'h600;
    #1;
    chk("pend_new.flush_id_ex", {31'b0, fe_w[0]}, 32'h1);
    step(); chk("pend_new.pc", pc_w[0], 32'h600); chk("pend_new.cnt", {16'b0, cnt0}, 32'd7);
    redir = 1'b0; stall = 1'b0;
    step(); chk("after.pc", pc_w[0], 32'h604);

    busy = 1'b1; redir = 1'b1; tgt = 32'h700;
    step();
    redir = 1'b0; rstn = 1'b0;
    #1;
    chk("mid_rst.pc", pc_w[0], 32'h0);
    step(); step();
    rstn = 1'b1; busy = 1'b0;
    #1;
    chk("post_rst.pc", pc_w[0], 32'h0);
    chk("post_rst.d1_pc", pc_w[1], 32'hFFFF_FFFC);
    step(); chk("post_rst.pc4", pc_w[0], 32'h4); chk("post_rst.cnt", {16'b0, cnt0}, 32'd0);
    step(); step();

    @(negedge CLK);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
